// File: rtl/bitstream_arg_decoder_if.sv
// Bundle of push/consume signals between a bitstream producer/consumer and bitstream_arg_decoder.
// Optional align input exists only when BITSTREAM_ARG_DECODER_ALIGN_EN is defined.
interface bitstream_arg_decoder_if #(
    parameter int WIDTH_IN  = 64,
    parameter int WIDTH_OUT = 64
);
    localparam int BW = $clog2(WIDTH_OUT + WIDTH_IN) + 1;
    localparam int PW = $clog2(WIDTH_OUT) + 1;

    // Handshake: a word on d is accepted at the edge where push=1 and full=0;
    // pop bits are consumed at the edge where 0 < pop (+pad) <= bits, otherwise nothing moves.
    logic                 push;
    logic [WIDTH_IN-1:0]  d;
    logic                 full;
    logic                 half_full;
    logic [WIDTH_OUT-1:0] q;
    logic                 ready;
    logic [BW-1:0]        bits;
    logic [PW-1:0]        pop;
    logic                 overflow;
    logic                 underflow;
`ifdef BITSTREAM_ARG_DECODER_ALIGN_EN
    logic                 align;

    modport master (
        output push, d, pop, align,
        input  full, half_full, q, ready, bits, overflow, underflow
    );
    modport slave (
        input  push, d, pop, align,
        output full, half_full, q, ready, bits, overflow, underflow
    );
`else
    modport master (
        output push, d, pop,
        input  full, half_full, q, ready, bits, overflow, underflow
    );
    modport slave (
        input  push, d, pop,
        output full, half_full, q, ready, bits, overflow, underflow
    );
`endif
endinterface

// File: rtl/bitstream_arg_decoder.sv
// Word FIFO feeding a bit buffer that exposes the next WIDTH_OUT stream bits, LSB first.
// Define BITSTREAM_ARG_DECODER_ALIGN_EN to add the align input and consumed-bit phase tracking.
module bitstream_arg_decoder #(
    parameter int WIDTH_IN          = 64,
    parameter int WIDTH_OUT         = 64,
    parameter int DEPTH             = 32,
    parameter int ALMOST_FULL_COUNT = 16,
    parameter int ALIGN_BITS        = 8
) (
    input logic clk,
    input logic rst,
    bitstream_arg_decoder_if.slave bus
);
    localparam int CAP = WIDTH_OUT + WIDTH_IN;
    localparam int BW  = $clog2(CAP) + 1;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;

    logic [WIDTH_IN-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic [CAP-1:0]      bit_buf;
    logic [BW-1:0]       bits_r;
    logic                overflow_r;
    logic                underflow_r;

    logic                full;
    logic                wr;
    logic                refill;
    logic                take;
    logic                under;
    logic [BW-1:0]       amt;
    logic [BW-1:0]       consumed;
    logic [BW-1:0]       remain;
    logic [CAP-1:0]      head_ext;
    logic [CAP-1:0]      buf_next;
    logic [BW-1:0]       bits_next;
    logic [CW-1:0]       count_next;

`ifdef BITSTREAM_ARG_DECODER_ALIGN_EN
    localparam int PHW = (ALIGN_BITS > 1) ? $clog2(ALIGN_BITS) : 1;
    logic [PHW-1:0] phase;
    logic [PHW-1:0] sum_lo;
    logic [PHW-1:0] pad;
`endif

    assign full = (count == CW'(DEPTH));
    assign wr   = bus.push && !full;

    always_comb begin
        amt = BW'(bus.pop);
`ifdef BITSTREAM_ARG_DECODER_ALIGN_EN
        sum_lo = '0;
        pad    = '0;
        if (bus.align) begin
            // Pad rounds the post-consume phase up to the next ALIGN_BITS boundary.
            sum_lo = phase + PHW'(bus.pop);
            pad    = PHW'(0) - sum_lo;
        end
        amt = BW'(bus.pop) + BW'(pad);
`endif
        take     = (amt != '0) && (amt <= bits_r);
        under    = (amt > bits_r);
        consumed = take ? amt : '0;
        remain   = bits_r - consumed;
        refill   = (count != '0) && ((int'(remain) + WIDTH_IN) <= CAP);
        head_ext = {{WIDTH_OUT{1'b0}}, mem[rd_ptr]};
        // Bits above bits_r are always zero, so OR-ing the new word in is safe.
        buf_next  = bit_buf >> consumed;
        bits_next = remain;
        if (refill) begin
            buf_next  = buf_next | (head_ext << remain);
            bits_next = remain + BW'(WIDTH_IN);
        end
        count_next = count + CW'(wr) - CW'(refill);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            bit_buf     <= '0;
            bits_r      <= '0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
`ifdef BITSTREAM_ARG_DECODER_ALIGN_EN
            phase       <= '0;
`endif
        end else begin
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (refill) rd_ptr <= rd_ptr + AW'(1);
            count   <= count_next;
            bit_buf <= buf_next;
            bits_r  <= bits_next;
            if (bus.push && full) overflow_r <= 1'b1;
            if (under) underflow_r <= 1'b1;
`ifdef BITSTREAM_ARG_DECODER_ALIGN_EN
            if (take) phase <= phase + PHW'(amt);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= bus.d;
    end

    assign bus.full      = full;
    assign bus.half_full = (count >= CW'(ALMOST_FULL_COUNT));
    assign bus.q         = bit_buf[WIDTH_OUT-1:0];
    assign bus.ready     = (bits_r >= BW'(WIDTH_OUT));
    assign bus.bits      = bits_r;
    assign bus.overflow  = overflow_r;
    assign bus.underflow = underflow_r;
endmodule

// File: tb/tb_bitstream_arg_decoder.sv
// Directed bench for bitstream_arg_decoder with WIDTH_IN=32, WIDTH_OUT=16, DEPTH=4, ALMOST_FULL_COUNT=2.
module tb_bitstream_arg_decoder;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    logic [15:0] exp_q [$];
    logic [31:0] w [5];
    logic [31:0] word;
    logic [15:0] e;
    int          n;

    bitstream_arg_decoder_if #(.WIDTH_IN(32), .WIDTH_OUT(16)) bus ();

    bitstream_arg_decoder #(
        .WIDTH_IN(32), .WIDTH_OUT(16), .DEPTH(4), .ALMOST_FULL_COUNT(2), .ALIGN_BITS(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        step();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        w[0] = 32'h11223344;
        w[1] = 32'h55667788;
        w[2] = 32'h99AABBCC;
        w[3] = 32'hDDEEFF00;
        w[4] = 32'h13579BDF;
        rst      = 1'b0;
        bus.push = 1'b0;
        bus.d    = '0;
        bus.pop  = '0;
`ifdef BITSTREAM_ARG_DECODER_ALIGN_EN
        bus.align = 1'b0;
`endif
        #12;
        chk("rst_full", bus.full, 0);
        chk("rst_half_full", bus.half_full, 0);
        chk("rst_ready", bus.ready, 0);
        chk("rst_q", bus.q, 0);
        chk("rst_bits", bus.bits, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_underflow", bus.underflow, 0);
        rst = 1'b1;
        step();

        // Single word: latency and one 16-bit pop
        bus.push = 1'b1; bus.d = 32'h89ABCDEF;
        step();
        bus.push = 1'b0;
        chk("first_bits_pre", bus.bits, 0);
        step();
        chk("first_bits", bus.bits, 32);
        chk("first_ready", bus.ready, 1);
        chk("first_q", bus.q, 16'hCDEF);
        bus.pop = 16;
        step();
        bus.pop = 0;
        chk("pop16_q", bus.q, 16'h89AB);
        chk("pop16_bits", bus.bits, 16);
        chk("pop16_underflow", bus.underflow, 0);

        // Underflow: pop exceeding occupancy is ignored and sticky
        bus.pop = 17;
        step();
        bus.pop = 0;
        chk("uf_bits", bus.bits, 16);
        chk("uf_q", bus.q, 16'h89AB);
        chk("uf_flag", bus.underflow, 1);
        step();
        chk("uf_sticky", bus.underflow, 1);
        bus.pop = 16;
        step();
        bus.pop = 0;
        chk("drain_bits", bus.bits, 0);
        chk("drain_ready", bus.ready, 0);
        chk("drain_q", bus.q, 0);
        chk("uf_sticky2", bus.underflow, 1);
        do_reset();
        chk("uf_cleared", bus.underflow, 0);

        // Fill the FIFO with no pops, then overflow
        for (int i = 0; i < 5; i++) begin
            bus.push = 1'b1; bus.d = w[i];
            exp_q.push_back(w[i][15:0]);
            exp_q.push_back(w[i][31:16]);
            step();
            chk($sformatf("fill_half_full_%0d", i), bus.half_full, (i >= 2) ? 1 : 0);
            chk($sformatf("fill_full_%0d", i), bus.full, (i == 4) ? 1 : 0);
            if (i >= 1) chk($sformatf("fill_bits_%0d", i), bus.bits, 32);
        end
        bus.d = 32'hDEADBEEF;
        step();
        bus.push = 1'b0;
        chk("ovf_flag", bus.overflow, 1);
        chk("ovf_full", bus.full, 1);
        chk("ovf_bits", bus.bits, 32);
        for (int k = 0; k < 10; k++) begin
            e = exp_q.pop_front();
            chk($sformatf("fill_ready_%0d", k), bus.ready, 1);
            chk($sformatf("fill_q_%0d", k), bus.q, e);
            bus.pop = 16;
            step();
        end
        bus.pop = 0;
        chk("fill_empty_bits", bus.bits, 0);
        chk("fill_empty_ready", bus.ready, 0);
        chk("ovf_sticky", bus.overflow, 1);
        do_reset();
        chk("ovf_cleared", bus.overflow, 0);

        // Continuous stream: push whenever not full, pop 16 whenever ready
        n = 0;
        for (int c = 0; c < 100; c++) begin
            if (!bus.full) begin
                word = 32'h0F1E2D3C + 32'(n) * 32'h01020304;
                bus.push = 1'b1; bus.d = word;
                exp_q.push_back(word[15:0]);
                exp_q.push_back(word[31:16]);
                n++;
            end else begin
                bus.push = 1'b0;
            end
            if (c >= 2) chk($sformatf("stream_ready_%0d", c), bus.ready, 1);
            if (bus.ready) begin
                e = exp_q.pop_front();
                chk($sformatf("stream_q_%0d", c), bus.q, e);
                bus.pop = 16;
            end else begin
                bus.pop = 0;
            end
            step();
        end
        bus.push = 1'b0;
        bus.pop  = 0;
        chk("stream_overflow", bus.overflow, 0);
        chk("stream_underflow", bus.underflow, 0);
        exp_q.delete();
        do_reset();

        // Mid-stream asynchronous reset at bits=40, count=3
        for (int i = 0; i < 5; i++) begin
            bus.push = 1'b1; bus.d = w[i];
            step();
        end
        bus.push = 1'b0;
        bus.pop = 16;
        step();
        bus.pop = 8;
        step();
        bus.pop = 0;
        chk("mid_bits", bus.bits, 40);
        chk("mid_q", bus.q, 16'h8811);
        chk("mid_half_full", bus.half_full, 1);
        rst = 1'b0;
        #1;
        chk("arst_ready", bus.ready, 0);
        chk("arst_full", bus.full, 0);
        chk("arst_half_full", bus.half_full, 0);
        chk("arst_q", bus.q, 0);
        chk("arst_bits", bus.bits, 0);
        #1;
        rst = 1'b1;
        bus.push = 1'b1; bus.d = 32'hCAFEF00D;
        step();
        bus.push = 1'b0;
        step();
        chk("post_rst_q", bus.q, 16'hF00D);
        chk("post_rst_bits", bus.bits, 32);

`ifdef BITSTREAM_ARG_DECODER_ALIGN_EN
        do_reset();
        bus.push = 1'b1; bus.d = w[0];
        step();
        bus.push = 1'b0;
        step();
        bus.pop = 3;
        step();
        bus.pop = 2; bus.align = 1'b1;
        step();
        bus.pop = 0; bus.align = 1'b0;
        chk("align_bits", bus.bits, 24);
        chk("align_q", bus.q, 16'h2233);
        chk("align_underflow", bus.underflow, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
